// File: rtl/mem_wb_stage_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | memwb_pkg                                                                  |
// | Shared encodings, FSM state type and offset helpers for mem_wb_stage.      |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
package memwb_pkg;

  localparam logic [1:0] C_WB_ALU  = 2'b00;
  localparam logic [1:0] C_WB_LOAD = 2'b01;
  localparam logic [1:0] C_WB_PC4  = 2'b10;
  localparam logic [1:0] C_WB_PCT  = 2'b11;

  // funct3[1:0] carries the access size; funct3[2] selects zero-extension
  localparam logic [1:0] C_SIZE_B = 2'b00;
  localparam logic [1:0] C_SIZE_H = 2'b01;
  localparam logic [1:0] C_SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DRAIN  = 2'd2
  } mem_state_e;

  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
    case (size)
      C_SIZE_H: return off[0];
      C_SIZE_W: return off != 2'b00;
      default:  return 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] eff_offset(input logic [1:0] size, input logic [1:0] off);
    case (size)
      C_SIZE_B: return off;
      C_SIZE_H: return {off[1], 1'b0};
      default:  return 2'b00;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_wb_stage_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_wb_stage_if                                                            |
// | EX-side, data-memory and writeback signals of the MEM/WB stage.            |
// | exc_misalign exists only when MEMWB_MISALIGN_EN is defined.                |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface mem_wb_stage_if #(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 8,
  parameter int RA_W   = 5
);
  logic              ex_valid;
  logic              ex_ready;
  logic [XLEN-1:0]   ex_alu_result;
  logic [XLEN-1:0]   ex_store_data;
  logic [2:0]        ex_funct3;
  logic [RA_W-1:0]   ex_rd;
  logic              ex_memread;
  logic              ex_memwrite;
  logic              ex_regwrite;
  logic [1:0]        ex_wb_sel;
  logic [XLEN-1:0]   ex_pc_plus4;
  logic [XLEN-1:0]   ex_pc_target;
  logic              flush;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-3:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN/8-1:0] mem_be;
  logic [XLEN-1:0]   mem_rdata;
  logic              mem_ack;
  logic              wb_valid;
  logic              wb_regwrite;
  logic [RA_W-1:0]   wb_rd;
  logic [XLEN-1:0]   wb_data;
`ifdef MEMWB_MISALIGN_EN
  logic              exc_misalign;
`endif

  modport slave (
    input  ex_valid, ex_alu_result, ex_store_data, ex_funct3, ex_rd,
           ex_memread, ex_memwrite, ex_regwrite, ex_wb_sel, ex_pc_plus4,
           ex_pc_target, flush, mem_rdata, mem_ack,
    output ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           wb_valid, wb_regwrite, wb_rd, wb_data
`ifdef MEMWB_MISALIGN_EN
    , output exc_misalign
`endif
  );

  modport master (
    output ex_valid, ex_alu_result, ex_store_data, ex_funct3, ex_rd,
           ex_memread, ex_memwrite, ex_regwrite, ex_wb_sel, ex_pc_plus4,
           ex_pc_target, flush, mem_rdata, mem_ack,
    input  ex_ready, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           wb_valid, wb_regwrite, wb_rd, wb_data
`ifdef MEMWB_MISALIGN_EN
    , input exc_misalign
`endif
  );

endinterface
`default_nettype wire

// File: rtl/mem_wb_stage_mem_access_fsm.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_access_fsm                                                             |
// | Tracks the data-memory access of the EX/MEM slot: request, retire, ready.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mem_access_fsm
  import memwb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ex_valid_i,
  input  logic cap_mem_i,
  input  logic exm_valid_i,
  input  logic flush_i,
  input  logic mem_ack_i,
  output logic mem_req_o,
  output logic retire_o,
  output logic ready_o,
  output logic capture_o,
  output logic discard_o
);

  mem_state_e state_q;
  logic       mem_req_q;
  logic       w_start;

  // Outside IDLE the slot always holds the op whose access is outstanding
  assign retire_o  = (state_q == ST_IDLE) ? exm_valid_i : mem_ack_i;
  assign ready_o   = rst && (!exm_valid_i || retire_o);
  assign capture_o = ex_valid_i && ready_o;
  assign discard_o = flush_i || (state_q == ST_DRAIN);
  assign w_start   = capture_o && cap_mem_i;
  assign mem_req_o = mem_req_q;

  // A draining access may complete in the same edge a new load/store is
  // captured, so DRAIN can hand straight over to ACCESS.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      mem_req_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (w_start) begin
            state_q   <= ST_ACCESS;
            mem_req_q <= 1'b1;
          end
        end
        ST_ACCESS: begin
          if (mem_ack_i) begin
            state_q   <= w_start ? ST_ACCESS : ST_IDLE;
            mem_req_q <= w_start;
          end else if (flush_i) begin
            state_q   <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (mem_ack_i) begin
            state_q   <= w_start ? ST_ACCESS : ST_IDLE;
            mem_req_q <= w_start;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mem_req_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/mem_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | mem_wb_stage                                                               |
// | EX/MEM register, variable-latency data-memory access, load/store lane      |
// | handling and MEM/WB register. Option: MEMWB_MISALIGN_EN (misalign trap).   |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module mem_wb_stage
  import memwb_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ADDR_W = 8,
  parameter int RA_W   = 5
) (
  input  logic           clk,
  input  logic           rst,
  mem_wb_stage_if.slave  bus
);

  localparam int BE_W = XLEN / 8;

  logic            exm_valid_q, exm_valid_d;
  logic [XLEN-1:0] exm_alu_q, exm_sdata_q, exm_pc4_q, exm_pct_q;
  logic [2:0]      exm_f3_q;
  logic [RA_W-1:0] exm_rd_q;
  logic            exm_mr_q, exm_mw_q, exm_rw_q;
  logic [1:0]      exm_wbsel_q;

  logic            wb_valid_q, wb_regwrite_q;
  logic [RA_W-1:0] wb_rd_q;
  logic [XLEN-1:0] wb_data_q;

  logic            w_mem_req, w_retire, w_ready, w_capture, w_discard, w_keep;
  logic            w_cap_mem, w_exc;
  logic [1:0]      w_eoff;
  logic [BE_W-1:0] w_be;
  logic [XLEN-1:0] w_wdata, w_shift, w_load, w_wb_data;

`ifdef MEMWB_MISALIGN_EN
  logic            exm_misal_q, exc_q, w_ex_misal;
  assign w_ex_misal = (bus.ex_memread || bus.ex_memwrite)
                      && is_misaligned(bus.ex_funct3[1:0], bus.ex_alu_result[1:0]);
  assign w_cap_mem  = (bus.ex_memread || bus.ex_memwrite) && !w_ex_misal;
  assign w_exc      = exm_misal_q;
  assign bus.exc_misalign = exc_q;
`else
  assign w_cap_mem  = bus.ex_memread || bus.ex_memwrite;
  assign w_exc      = 1'b0;
`endif

  mem_access_fsm u_fsm (
    .clk        (clk),
    .rst        (rst),
    .ex_valid_i (bus.ex_valid),
    .cap_mem_i  (w_cap_mem),
    .exm_valid_i(exm_valid_q),
    .flush_i    (bus.flush),
    .mem_ack_i  (bus.mem_ack),
    .mem_req_o  (w_mem_req),
    .retire_o   (w_retire),
    .ready_o    (w_ready),
    .capture_o  (w_capture),
    .discard_o  (w_discard)
  );

  assign exm_valid_d = w_capture ? 1'b1 : (w_retire ? 1'b0 : exm_valid_q);

  always_ff @(posedge clk) begin
    if (!rst) begin
      exm_valid_q <= 1'b0;
      exm_alu_q   <= '0;
      exm_sdata_q <= '0;
      exm_pc4_q   <= '0;
      exm_pct_q   <= '0;
      exm_f3_q    <= '0;
      exm_rd_q    <= '0;
      exm_mr_q    <= 1'b0;
      exm_mw_q    <= 1'b0;
      exm_rw_q    <= 1'b0;
      exm_wbsel_q <= '0;
`ifdef MEMWB_MISALIGN_EN
      exm_misal_q <= 1'b0;
`endif
    end else begin
      exm_valid_q <= exm_valid_d;
      if (w_capture) begin
        exm_alu_q   <= bus.ex_alu_result;
        exm_sdata_q <= bus.ex_store_data;
        exm_pc4_q   <= bus.ex_pc_plus4;
        exm_pct_q   <= bus.ex_pc_target;
        exm_f3_q    <= bus.ex_funct3;
        exm_rd_q    <= bus.ex_rd;
        exm_mr_q    <= bus.ex_memread;
        exm_mw_q    <= bus.ex_memwrite;
        exm_rw_q    <= bus.ex_regwrite;
        exm_wbsel_q <= bus.ex_wb_sel;
`ifdef MEMWB_MISALIGN_EN
        exm_misal_q <= w_ex_misal;
`endif
      end
    end
  end

  // Sub-word offsets are rounded down so halfwords/words never straddle lanes
  assign w_eoff = eff_offset(exm_f3_q[1:0], exm_alu_q[1:0]);

  always_comb begin
    w_be    = '1;
    w_wdata = exm_sdata_q;
    case (exm_f3_q[1:0])
      C_SIZE_B: begin
        w_be    = BE_W'(1) << w_eoff;
        w_wdata = {BE_W{exm_sdata_q[7:0]}};
      end
      C_SIZE_H: begin
        w_be    = BE_W'(3) << w_eoff;
        w_wdata = {(XLEN/16){exm_sdata_q[15:0]}};
      end
      default: ;
    endcase
  end

  assign bus.mem_req   = w_mem_req;
  assign bus.mem_we    = w_mem_req && exm_mw_q;
  assign bus.mem_addr  = w_mem_req ? exm_alu_q[ADDR_W-1:2] : '0;
  assign bus.mem_wdata = w_mem_req ? w_wdata : '0;
  assign bus.mem_be    = w_mem_req ? w_be : '0;

  assign w_shift = bus.mem_rdata >> {w_eoff, 3'b000};

  always_comb begin
    w_load = w_shift;
    case (exm_f3_q)
      3'b000: w_load = {{(XLEN-8){w_shift[7]}}, w_shift[7:0]};
      3'b001: w_load = {{(XLEN-16){w_shift[15]}}, w_shift[15:0]};
      3'b100: w_load = {{(XLEN-8){1'b0}}, w_shift[7:0]};
      3'b101: w_load = {{(XLEN-16){1'b0}}, w_shift[15:0]};
      default: ;
    endcase
  end

  always_comb begin
    w_wb_data = exm_alu_q;
    case (exm_wbsel_q)
      C_WB_LOAD: w_wb_data = w_load;
      C_WB_PC4:  w_wb_data = exm_pc4_q;
      C_WB_PCT:  w_wb_data = exm_pct_q;
      default:   ;
    endcase
  end

  assign w_keep = w_retire && !w_discard;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_valid_q    <= 1'b0;
      wb_regwrite_q <= 1'b0;
      wb_rd_q       <= '0;
      wb_data_q     <= '0;
`ifdef MEMWB_MISALIGN_EN
      exc_q         <= 1'b0;
`endif
    end else begin
      wb_valid_q    <= w_keep;
      wb_regwrite_q <= w_keep && exm_rw_q && !w_exc;
`ifdef MEMWB_MISALIGN_EN
      exc_q         <= w_keep && w_exc;
`endif
      if (w_retire) begin
        wb_rd_q   <= exm_rd_q;
        wb_data_q <= w_wb_data;
      end
    end
  end

  assign bus.ex_ready    = w_ready;
  assign bus.wb_valid    = wb_valid_q;
  assign bus.wb_regwrite = wb_regwrite_q;
  assign bus.wb_rd       = wb_rd_q;
  assign bus.wb_data     = wb_data_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_mem_wb_stage                                                            |
// | Directed self-checking bench for mem_wb_stage (honours MEMWB_MISALIGN_EN). |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module tb_mem_wb_stage;
  import memwb_pkg::*;

  localparam int XLEN   = 32;
  localparam int ADDR_W = 8;
  localparam int RA_W   = 5;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mem_wb_stage_if #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RA_W(RA_W)) u_bus ();

  mem_wb_stage #(.XLEN(XLEN), .ADDR_W(ADDR_W), .RA_W(RA_W)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(u_bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] alu, input logic [31:0] sdata, input logic [2:0] f3,
                      input logic [4:0] rd, input logic mr, input logic mw, input logic rw,
                      input logic [1:0] wbsel, input logic [31:0] pc4, input logic [31:0] pct);
    u_bus.ex_valid      = 1'b1;
    u_bus.ex_alu_result = alu;
    u_bus.ex_store_data = sdata;
    u_bus.ex_funct3     = f3;
    u_bus.ex_rd         = rd;
    u_bus.ex_memread    = mr;
    u_bus.ex_memwrite   = mw;
    u_bus.ex_regwrite   = rw;
    u_bus.ex_wb_sel     = wbsel;
    u_bus.ex_pc_plus4   = pc4;
    u_bus.ex_pc_target  = pct;
  endtask

  task automatic idle();
    send(32'h0, 32'h0, 3'b000, 5'd0, 1'b0, 1'b0, 1'b0, C_WB_ALU, 32'h0, 32'h0);
    u_bus.ex_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle();
    u_bus.flush     = 1'b0;
    u_bus.mem_ack   = 1'b0;
    u_bus.mem_rdata = 32'h0;
    tick();
    tick();
    check("rst_wb_valid", u_bus.wb_valid, 32'h0);
    check("rst_mem_req",  u_bus.mem_req,  32'h0);
    check("rst_ex_ready", u_bus.ex_ready, 32'h0);
    check("rst_wb_data",  u_bus.wb_data,  32'h0);
    rst = 1'b1;

    // LW at 0x10, zero-wait ack
    send(32'h10, 32'h0, 3'b010, 5'd5, 1'b1, 1'b0, 1'b1, C_WB_LOAD, 32'h0, 32'h0);
    #1 check("lw_ready", u_bus.ex_ready, 32'h1);
    tick();
    idle();
    u_bus.mem_ack   = 1'b1;
    u_bus.mem_rdata = 32'hDEADBEEF;
    #1;
    check("lw_req",      u_bus.mem_req,  32'h1);
    check("lw_addr",     u_bus.mem_addr, 32'h4);
    check("lw_we",       u_bus.mem_we,   32'h0);
    check("lw_wb_early", u_bus.wb_valid, 32'h0);
    tick();
    u_bus.mem_ack = 1'b0;
    #1;
    check("lw_wb_valid",    u_bus.wb_valid,    32'h1);
    check("lw_wb_data",     u_bus.wb_data,     32'hDEADBEEF);
    check("lw_wb_rd",       u_bus.wb_rd,       32'h5);
    check("lw_wb_regwrite", u_bus.wb_regwrite, 32'h1);
    check("lw_req_done",    u_bus.mem_req,     32'h0);

    // LB then LBU at offset 3, back to back
    send(32'h13, 32'h0, 3'b000, 5'd6, 1'b1, 1'b0, 1'b1, C_WB_LOAD, 32'h0, 32'h0);
    tick();
    send(32'h13, 32'h0, 3'b100, 5'd7, 1'b1, 1'b0, 1'b1, C_WB_LOAD, 32'h0, 32'h0);
    u_bus.mem_ack   = 1'b1;
    u_bus.mem_rdata = 32'h80FFFFFF;
    #1 check("b2b_ready", u_bus.ex_ready, 32'h1);
    tick();
    idle();
    #1;
    check("lb_data", u_bus.wb_data, 32'hFFFFFF80);
    check("lb_rd",   u_bus.wb_rd,   32'h6);
    check("b2b_req", u_bus.mem_req, 32'h1);
    tick();
    u_bus.mem_ack = 1'b0;
    #1;
    check("lbu_valid", u_bus.wb_valid, 32'h1);
    check("lbu_data",  u_bus.wb_data,  32'h00000080);
    check("lbu_rd",    u_bus.wb_rd,    32'h7);

    // SH at offset 2
    send(32'h22, 32'h0000ABCD, 3'b001, 5'd9, 1'b0, 1'b1, 1'b0, C_WB_ALU, 32'h0, 32'h0);
    tick();
    idle();
    u_bus.mem_ack = 1'b1;
    #1;
    check("sh_be",       u_bus.mem_be,           32'hC);
    check("sh_wdata_hi", u_bus.mem_wdata[31:16], 32'hABCD);
    check("sh_we",       u_bus.mem_we,           32'h1);
    check("sh_addr",     u_bus.mem_addr,         32'h8);
    tick();
    u_bus.mem_ack = 1'b0;
    #1;
    check("sh_wb_valid",    u_bus.wb_valid,    32'h1);
    check("sh_wb_regwrite", u_bus.wb_regwrite, 32'h0);

    // LW with three wait states, ADD stalled behind it
    send(32'h40, 32'h0, 3'b010, 5'd10, 1'b1, 1'b0, 1'b1, C_WB_LOAD, 32'h0, 32'h0);
    tick();
    send(32'h55, 32'h0, 3'b000, 5'd11, 1'b0, 1'b0, 1'b1, C_WB_ALU, 32'h0, 32'h0);
    u_bus.mem_rdata = 32'h12345678;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("wait_ready", u_bus.ex_ready, 32'h0);
      check("wait_addr",  u_bus.mem_addr, 32'h10);
      check("wait_wbv",   u_bus.wb_valid, 32'h0);
      tick();
    end
    u_bus.mem_ack = 1'b1;
    #1 check("wait_ack_ready", u_bus.ex_ready, 32'h1);
    tick();
    idle();
    u_bus.mem_ack = 1'b0;
    #1;
    check("wait_wb_valid", u_bus.wb_valid, 32'h1);
    check("wait_wb_data",  u_bus.wb_data,  32'h12345678);
    check("wait_wb_rd",    u_bus.wb_rd,    32'hA);
    check("wait_req_off",  u_bus.mem_req,  32'h0);
    tick();
    check("add_wb_data",     u_bus.wb_data,     32'h55);
    check("add_wb_rd",       u_bus.wb_rd,       32'hB);
    check("add_wb_regwrite", u_bus.wb_regwrite, 32'h1);

    // Flush of a load while its access is outstanding
    send(32'h20, 32'h0, 3'b010, 5'd12, 1'b1, 1'b0, 1'b1, C_WB_LOAD, 32'h0, 32'h0);
    tick();
    idle();
    u_bus.flush = 1'b1;
    #1 check("fl_req", u_bus.mem_req, 32'h1);
    tick();
    u_bus.flush = 1'b0;
    #1;
    check("fl_drain_req",   u_bus.mem_req,  32'h1);
    check("fl_drain_ready", u_bus.ex_ready, 32'h0);
    check("fl_drain_wbv",   u_bus.wb_valid, 32'h0);
    u_bus.mem_ack   = 1'b1;
    u_bus.mem_rdata = 32'hCAFEF00D;
    #1 check("fl_ack_ready", u_bus.ex_ready, 32'h1);
    tick();
    u_bus.mem_ack = 1'b0;
    #1;
    check("fl_no_wb",  u_bus.wb_valid, 32'h0);
    check("fl_req_off", u_bus.mem_req, 32'h0);

    // Flush of a captured JAL while an AUIPC is accepted in the same cycle
    send(32'h0, 32'h0, 3'b000, 5'd1, 1'b0, 1'b0, 1'b1, C_WB_PC4, 32'h104, 32'h0);
    tick();
    send(32'h0, 32'h0, 3'b000, 5'd3, 1'b0, 1'b0, 1'b1, C_WB_PCT, 32'h0, 32'h2000);
    u_bus.flush = 1'b1;
    #1 check("fa_ready", u_bus.ex_ready, 32'h1);
    tick();
    idle();
    u_bus.flush = 1'b0;
    #1 check("fa_killed", u_bus.wb_valid, 32'h0);
    tick();
    check("auipc_valid", u_bus.wb_valid, 32'h1);
    check("auipc_data",  u_bus.wb_data,  32'h2000);
    check("auipc_rd",    u_bus.wb_rd,    32'h3);

    // Unflushed JAL writes back the link value
    send(32'h0, 32'h0, 3'b000, 5'd1, 1'b0, 1'b0, 1'b1, C_WB_PC4, 32'h104, 32'h0);
    tick();
    idle();
    tick();
    check("jal_data", u_bus.wb_data, 32'h104);
    check("jal_rd",   u_bus.wb_rd,   32'h1);

`ifdef MEMWB_MISALIGN_EN
    send(32'h12, 32'h0, 3'b010, 5'd13, 1'b1, 1'b0, 1'b1, C_WB_LOAD, 32'h0, 32'h0);
    tick();
    idle();
    #1 check("ma_req", u_bus.mem_req, 32'h0);
    tick();
    check("ma_valid",    u_bus.wb_valid,     32'h1);
    check("ma_exc",      u_bus.exc_misalign, 32'h1);
    check("ma_regwrite", u_bus.wb_regwrite,  32'h0);
    tick();
    check("ma_exc_clr",  u_bus.exc_misalign, 32'h0);
`else
    // Without the trap, a misaligned word is truncated to its word address
    send(32'h12, 32'h0, 3'b010, 5'd13, 1'b1, 1'b0, 1'b1, C_WB_LOAD, 32'h0, 32'h0);
    tick();
    idle();
    u_bus.mem_ack   = 1'b1;
    u_bus.mem_rdata = 32'hA5A51234;
    #1 check("tr_addr", u_bus.mem_addr, 32'h4);
    tick();
    u_bus.mem_ack = 1'b0;
    #1 check("tr_lw_data", u_bus.wb_data, 32'hA5A51234);
    send(32'h13, 32'h0, 3'b001, 5'd14, 1'b1, 1'b0, 1'b1, C_WB_LOAD, 32'h0, 32'h0);
    tick();
    idle();
    u_bus.mem_ack   = 1'b1;
    u_bus.mem_rdata = 32'h80FFFFFF;
    tick();
    u_bus.mem_ack = 1'b0;
    #1 check("tr_lh_data", u_bus.wb_data, 32'hFFFF80FF);
`endif

    // Reset while waiting for an ack abandons the request
    send(32'h30, 32'h0, 3'b010, 5'd15, 1'b1, 1'b0, 1'b1, C_WB_LOAD, 32'h0, 32'h0);
    tick();
    idle();
    #1 check("rw_req", u_bus.mem_req, 32'h1);
    rst = 1'b0;
    tick();
    check("rw_req_off", u_bus.mem_req,  32'h0);
    check("rw_addr",    u_bus.mem_addr, 32'h0);
    check("rw_ready",   u_bus.ex_ready, 32'h0);
    check("rw_wbv",     u_bus.wb_valid, 32'h0);
    check("rw_wb_data", u_bus.wb_data,  32'h0);
    rst = 1'b1;
    #1 check("rw_ready_after", u_bus.ex_ready, 32'h1);
    tick();
    check("rw_req_idle", u_bus.mem_req, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
